// File: rtl/cdb_arbiter_buffer_if.sv
// Producer-side push channels and CDB broadcast bus for cdb_arbiter_buffer.
// The slave modport is the buffer; the master modport is the functional-unit/consumer side.
interface cdb_arbiter_buffer_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
);
    localparam int SRC_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_ready;
    logic [NUM_CH*TAG_W-1:0]  in_tag;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic                     cdb_stall;
    logic                     cdb_valid;
    logic [TAG_W-1:0]         cdb_tag;
    logic [DATA_W-1:0]        cdb_data;
    logic [SRC_W-1:0]         cdb_src;

    modport slave (
        input  in_valid, in_tag, in_data, cdb_stall,
        output in_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
    );

    modport master (
        output in_valid, in_tag, in_data, cdb_stall,
        input  in_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter_buffer.sv
// Per-channel result FIFOs feeding a round-robin, registered CDB broadcast.
// Optional macro CDB_BYPASS_EN lets an empty channel's incoming result win directly.
module cdb_arbiter_buffer #(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    cdb_arbiter_buffer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SRC_W = $clog2(NUM_CH);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] EMPTY_CNT = {CNT_W{1'b0}};

    logic [TAG_W-1:0]  tag_mem_q  [NUM_CH][DEPTH];
    logic [DATA_W-1:0] data_mem_q [NUM_CH][DEPTH];

    logic [PTR_W-1:0]  head_q  [NUM_CH];
    logic [PTR_W-1:0]  head_d  [NUM_CH];
    logic [PTR_W-1:0]  tail_q  [NUM_CH];
    logic [PTR_W-1:0]  tail_d  [NUM_CH];
    logic [CNT_W-1:0]  count_q [NUM_CH];
    logic [CNT_W-1:0]  count_d [NUM_CH];

    logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
    logic [SRC_W-1:0]  cdb_src_q, cdb_src_d;

    logic [NUM_CH-1:0] rdy_s;
    logic [NUM_CH-1:0] cand_s;
    logic [NUM_CH-1:0] push_s;
    logic [NUM_CH-1:0] pop_s;
    logic [NUM_CH-1:0] wr_s;
    logic              grant_s;
    logic [SRC_W-1:0]  win_s;

    // Space available, push qualification and arbitration candidates per channel.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            rdy_s[i]  = (count_q[i] != FULL_CNT) && !rst_i;
            push_s[i] = bus.in_valid[i] && rdy_s[i];
`ifdef CDB_BYPASS_EN
            cand_s[i] = (count_q[i] != EMPTY_CNT) || bus.in_valid[i];
`else
            cand_s[i] = (count_q[i] != EMPTY_CNT);
`endif
        end
    end

    // Round-robin pick: scanning downward lets the candidate nearest rr_ptr overwrite the rest.
    always_comb begin
        int idx;
        idx   = 0;
        win_s = rr_ptr_q;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx   = (int'(rr_ptr_q) + k) % NUM_CH;
            win_s = cand_s[idx] ? SRC_W'(idx) : win_s;
        end
        grant_s = !bus.cdb_stall && (|cand_s);
    end

    // Pop/write qualification and FIFO pointer/count next state.
    always_comb begin
        logic sel;
        sel = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel      = grant_s && (win_s == SRC_W'(i));
            pop_s[i] = sel && (count_q[i] != EMPTY_CNT);
`ifdef CDB_BYPASS_EN
            wr_s[i]  = push_s[i] && !(sel && (count_q[i] == EMPTY_CNT));
`else
            wr_s[i]  = push_s[i];
`endif
            if (pop_s[i]) begin
                head_d[i] = head_q[i] + PTR_W'(1);
            end else begin
                head_d[i] = head_q[i];
            end
            if (wr_s[i]) begin
                tail_d[i] = tail_q[i] + PTR_W'(1);
            end else begin
                tail_d[i] = tail_q[i];
            end
            case ({wr_s[i], pop_s[i]})
                2'b10:   count_d[i] = count_q[i] + CNT_W'(1);
                2'b01:   count_d[i] = count_q[i] - CNT_W'(1);
                default: count_d[i] = count_q[i];
            endcase
        end
    end

    // Broadcast register next state; without a grant everything but valid holds.
    always_comb begin
        cdb_valid_d = grant_s;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        cdb_src_d   = cdb_src_q;
        rr_ptr_d    = rr_ptr_q;
        if (grant_s) begin
            cdb_src_d = win_s;
            rr_ptr_d  = SRC_W'((int'(win_s) + 1) % NUM_CH);
`ifdef CDB_BYPASS_EN
            if (count_q[win_s] == EMPTY_CNT) begin
                cdb_tag_d  = bus.in_tag[int'(win_s)*TAG_W +: TAG_W];
                cdb_data_d = bus.in_data[int'(win_s)*DATA_W +: DATA_W];
            end else begin
                cdb_tag_d  = tag_mem_q[win_s][head_q[win_s]];
                cdb_data_d = data_mem_q[win_s][head_q[win_s]];
            end
`else
            cdb_tag_d  = tag_mem_q[win_s][head_q[win_s]];
            cdb_data_d = data_mem_q[win_s][head_q[win_s]];
`endif
        end else begin
            cdb_src_d = cdb_src_q;
        end
    end

    // Control state: reset clears everything, flush empties FIFOs but keeps rr_ptr and data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_CH; i++) begin
                head_q[i]  <= {PTR_W{1'b0}};
                tail_q[i]  <= {PTR_W{1'b0}};
                count_q[i] <= EMPTY_CNT;
            end
            rr_ptr_q    <= {SRC_W{1'b0}};
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= {TAG_W{1'b0}};
            cdb_data_q  <= {DATA_W{1'b0}};
            cdb_src_q   <= {SRC_W{1'b0}};
        end else if (flush_i) begin
            for (int i = 0; i < NUM_CH; i++) begin
                head_q[i]  <= {PTR_W{1'b0}};
                tail_q[i]  <= {PTR_W{1'b0}};
                count_q[i] <= EMPTY_CNT;
            end
            cdb_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                head_q[i]  <= head_d[i];
                tail_q[i]  <= tail_d[i];
                count_q[i] <= count_d[i];
            end
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    // FIFO storage; contents are don't-care once count drops to zero.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_s[i] && !flush_i) begin
                tag_mem_q[i][tail_q[i]]  <= bus.in_tag[i*TAG_W +: TAG_W];
                data_mem_q[i][tail_q[i]] <= bus.in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign bus.in_ready  = rdy_s;
    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_data  = cdb_data_q;
    assign bus.cdb_src   = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter_buffer.sv
// Scoreboard bench for cdb_arbiter_buffer: accepted pushes are queued per channel and
// matched against broadcasts in per-channel FIFO order; directed checks cover ordering.
module tb_cdb_arbiter_buffer;
    localparam int NUM_CH = 4;
    localparam int DEPTH  = 2;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 4;
`ifdef CDB_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    bit   clk;
    logic rst, flush;

    cdb_arbiter_buffer_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    cdb_arbiter_buffer #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .bus     (bus)
    );

    typedef struct {
        int                ch;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } sb_t;

    sb_t sb_q[$];
    int  total;
    int  bad;
    int  bcast_cnt;
    int  mon_hit;
    int  base;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        bus.in_tag[ch*TAG_W +: TAG_W]    = t;
        bus.in_data[ch*DATA_W +: DATA_W] = d;
    endtask

    // Scoreboard: compare broadcasts first, then record what the coming edge accepts.
    always @(negedge clk) begin
        if (bus.cdb_valid === 1'b1) begin
            mon_hit = -1;
            for (int j = 0; j < sb_q.size(); j++) begin
                if (mon_hit < 0 && sb_q[j].ch == int'(bus.cdb_src)) mon_hit = j;
            end
            bcast_cnt++;
            chk("sb_avail", mon_hit >= 0, 64'd1);
            if (mon_hit >= 0) begin
                chk("sb_tag", bus.cdb_tag, sb_q[mon_hit].tag);
                chk("sb_data", bus.cdb_data, sb_q[mon_hit].data);
                sb_q.delete(mon_hit);
            end
        end
        if (rst === 1'b1 || flush === 1'b1) begin
            sb_q.delete();
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (bus.in_valid[c] === 1'b1 && bus.in_ready[c] === 1'b1)
                    sb_q.push_back('{c, bus.in_tag[c*TAG_W +: TAG_W], bus.in_data[c*DATA_W +: DATA_W]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0; bcast_cnt = 0; mon_hit = 0; base = 0;
        rst = 1'b1; flush = 1'b0;
        bus.cdb_stall = 1'b0;
        bus.in_valid  = 4'hF;
        bus.in_tag    = 16'h5A5A;
        bus.in_data   = {4{32'hCAFE0123}};

        // reset with all producers requesting
        step;
        chk("rst_ready_a", bus.in_ready, 4'h0);
        step;
        chk("rst_ready_b", bus.in_ready, 4'h0);
        chk("rst_valid", bus.cdb_valid, 1'b0);
        chk("rst_tag", bus.cdb_tag, 4'h0);
        chk("rst_data", bus.cdb_data, 32'h0);
        chk("rst_src", bus.cdb_src, 2'd0);
        rst = 1'b0;
        bus.in_valid = 4'h0;
        step;
        chk("rst_ready_after", bus.in_ready, 4'hF);
        chk("rst_valid_after", bus.cdb_valid, 1'b0);

        // single push on channel 2
        set_ch(2, 4'd5, 32'hDEADBEEF);
        bus.in_valid = 4'b0100;
        step;
        bus.in_valid = 4'h0;
        for (int c = 1; c < LAT; c++) begin
            chk("single_early", bus.cdb_valid, 1'b0);
            step;
        end
        chk("single_valid", bus.cdb_valid, 1'b1);
        chk("single_tag", bus.cdb_tag, 4'd5);
        chk("single_data", bus.cdb_data, 32'hDEADBEEF);
        chk("single_src", bus.cdb_src, 2'd2);
        step;
        chk("single_pulse", bus.cdb_valid, 1'b0);
        chk("single_hold_tag", bus.cdb_tag, 4'd5);
        chk("single_hold_data", bus.cdb_data, 32'hDEADBEEF);

        // round-robin fairness from rr_ptr=0
        rst = 1'b1;
        step;
        rst = 1'b0;
        bus.cdb_stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < NUM_CH; c++) set_ch(c, TAG_W'(4*c + k), 32'hA0000000 + 32'(c*16 + k));
            bus.in_valid = 4'hF;
            step;
        end
        bus.in_valid = 4'h0;
        chk("fill_full", bus.in_ready, 4'h0);
        bus.cdb_stall = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step;
            chk("rr_valid", bus.cdb_valid, 1'b1);
            chk("rr_src", bus.cdb_src, 64'(i % 4));
            chk("rr_tag", bus.cdb_tag, 64'(4*(i % 4) + i / 4));
        end
        step;
        chk("rr_idle", bus.cdb_valid, 1'b0);

        // backpressure: three pushes on ch1 under stall, only two accepted
        bus.cdb_stall = 1'b1;
        for (int j = 0; j < 3; j++) begin
            set_ch(1, TAG_W'(8 + j), 32'h11110000 + 32'(j));
            bus.in_valid = 4'b0010;
            chk("bp_ready", bus.in_ready[1], 64'(j < 2));
            step;
        end
        bus.in_valid = 4'h0;
        chk("bp_full", bus.in_ready[1], 1'b0);
        base = bcast_cnt;
        bus.cdb_stall = 1'b0;
        repeat (6) step;
        chk("bp_count", bcast_cnt - base, 64'd2);

        // flush mid-stream with five entries queued
        bus.cdb_stall = 1'b1;
        for (int c = 0; c < NUM_CH; c++) set_ch(c, TAG_W'(c + 1), 32'h55000000 + 32'(c));
        bus.in_valid = 4'hF;
        step;
        set_ch(0, 4'hE, 32'h55FF0000);
        bus.in_valid = 4'b0001;
        step;
        bus.in_valid = 4'h0;
        bus.cdb_stall = 1'b0;
        step;
        chk("fl_pre_valid", bus.cdb_valid, 1'b1);
        flush = 1'b1;
        bus.in_valid = 4'hF;
        step;
        flush = 1'b0;
        bus.in_valid = 4'h0;
        chk("fl_valid", bus.cdb_valid, 1'b0);
        chk("fl_ready", bus.in_ready, 4'hF);
        base = bcast_cnt;
        repeat (6) step;
        chk("fl_none", bcast_cnt - base, 64'd0);

        // simultaneous push and pop on a full channel 0
        bus.cdb_stall = 1'b1;
        for (int j = 0; j < 2; j++) begin
            set_ch(0, TAG_W'(1 + j), 32'h0C0C0000 + 32'(j));
            bus.in_valid = 4'b0001;
            step;
        end
        chk("pp_full", bus.in_ready[0], 1'b0);
        bus.cdb_stall = 1'b0;
        set_ch(0, 4'd3, 32'h00000BAD);
        bus.in_valid = 4'b0001;
        step;
        bus.in_valid = 4'h0;
        chk("pp_ready_next", bus.in_ready[0], 1'b1);
        chk("pp_valid", bus.cdb_valid, 1'b1);
        chk("pp_tag", bus.cdb_tag, 4'd1);
        base = bcast_cnt;
        repeat (4) step;
        chk("pp_drain", bcast_cnt - base, 64'd2);

        chk("sb_empty", sb_q.size(), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter_buffer.md
# cdb_arbiter_buffer

Parametrised common-data-bus capture and broadcast stage for the Tomasulo back end. It sits between the functional units and the CDB. Each unit pushes {tag, data} results into a private FIFO channel. A round-robin arbiter then drives one registered broadcast per cycle onto the CDB. It generalises the single-entry CDB data latch to N channels with depth, tags, flow control and flush.

## Interface

Parameters:

- NUM_CH, 4: number of producer channels (≥2).
- DEPTH, 2: entries per channel FIFO (power of 2, ≥2).
- DATA_W, 32: result data width.
- TAG_W, 4: ROB/RS tag width.

Ports:

- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous pipeline flush (mispredict).
- in_valid  in  NUM_CH  per-channel push request.
- in_ready  out  NUM_CH  per-channel space available.
- in_tag  in  NUM_CH*TAG_W  channel i tag at bits [i*TAG_W +: TAG_W].
- in_data  in  NUM_CH*DATA_W  channel i data at bits [i*DATA_W +: DATA_W].
- cdb_stall  in  1  consumer cannot accept a broadcast this cycle.
- cdb_valid  out  1  broadcast valid.
- cdb_tag  out  TAG_W  broadcast tag.
- cdb_data  out  DATA_W  broadcast data.
- cdb_src  out  $clog2(NUM_CH)  winning channel index.

## Operation

- **Push.** A push on channel i occurs when in_valid[i] && in_ready[i]. It writes {tag, data} at the tail of FIFO i.
- **in_ready.** in_ready[i] = (count[i] != DEPTH) && !rst. It is computed from registered count only. A same-cycle pop does not raise it, so a full FIFO never accepts a push.
- **Candidates.** Channel i is a candidate when count[i] != 0.
- **Arbitration.** When cdb_stall=0 and at least one candidate exists:
  - The winner w is the first candidate found scanning rr_ptr, rr_ptr+1, … mod NUM_CH.
  - Pop the head of FIFO w.
  - Register it to cdb_tag/cdb_data, set cdb_src<=w and cdb_valid<=1.
  - Update rr_ptr <= (w+1) mod NUM_CH.
- **No grant.** If there are no candidates or cdb_stall=1: cdb_valid<=0, and rr_ptr, cdb_tag, cdb_data and cdb_src hold their previous values (latch-hold behaviour).
- **Simultaneous push and pop** on one channel: count unchanged, pointers both advance.
- **Pointer wrap.** Head and tail pointers are $clog2(DEPTH) bits and wrap naturally. count is $clog2(DEPTH)+1 bits.
- **Flush.** All counts and pointers go to 0 and cdb_valid<=0. Pushes and any grant in the flush cycle are discarded. rr_ptr and data outputs hold.
- **Reset.** Overrides flush. Results:
  - counts, head and tail pointers = 0.
  - rr_ptr = 0.
  - cdb_valid = 0, cdb_tag = 0, cdb_data = 0, cdb_src = 0.
  - in_ready = 0 while rst is high, all 1 the cycle after.
  - Reset asserted mid-stream drops all queued entries.

## Timing

- Push to broadcast latency is 2 cycles with the macro off:
  - Edge 1 writes the FIFO.
  - Edge 2 registers the CDB output.
- cdb_valid is a one-cycle pulse per broadcast. Back-to-back broadcasts are allowed every cycle.
- Throughput is 1 broadcast per cycle aggregate. With all channels busy, each channel gets at least 1 grant per NUM_CH cycles.
- cdb_stall acts in the same cycle: it suppresses the grant decided in that cycle.

## Configuration

- **CDB_BYPASS_EN undefined:** only entries already in a FIFO are candidates. Latency is 2 cycles.
- **CDB_BYPASS_EN defined:** a channel with count[i]==0 and in_valid[i]==1 is also a candidate.
  - If it wins, its input goes directly to the CDB registers with latency 1, and the FIFO is not written.
  - If it loses, the push enters the FIFO normally.
  - in_ready is unchanged.
  - Flush and rst still discard the bypass.

## Test plan

- **Reset:** assert rst for 2 cycles with in_valid=all 1. Required: cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, in_ready=0000 during rst, 1111 after.
- **Single push:** push ch2 tag=5, data=0xDEADBEEF. Required: cdb_valid=1 with tag 5, data 0xDEADBEEF, src 2 exactly 2 cycles later (1 with CDB_BYPASS_EN). Then cdb_valid=0, with tag and data held.
- **Round-robin fairness:** fill all 4 channels with 2 entries each, tags = 4*ch+k. Required: grant order 0,1,2,3,0,1,2,3 over 8 consecutive cycles, with FIFO order preserved per channel.
- **Full / backpressure:** hold cdb_stall=1 and push 3 times on ch1. Required:
  - in_ready[1]=0 after 2 accepts; the third push is not accepted.
  - Releasing stall yields exactly 2 broadcasts.
- **Flush mid-stream:** queue 5 entries, assert flush while cdb_valid=1. Required: the next cycle cdb_valid=0, all in_ready=1, and no further broadcasts.
- **Simultaneous push/pop at full:** with ch0 full and granted while in_valid[0]=1, the push is rejected (in_ready=0). The next cycle in_ready[0]=1.
